// File: rtl/fft_frame_pkg.sv
// Shared types and helpers for the FFT frame loader.
package fft_frame_pkg;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    START = 3'd3,
    RUN   = 3'd4,
    HOLD  = 3'd5
  } state_t;

  // Sign-extend the low i_w bits of i_val to 32 bits.
  function automatic logic [31:0] sext(input logic [31:0] i_val, input int i_w);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      v[i] = (i < i_w) ? i_val[i] : i_val[i_w-1];
    end
    return v;
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample stream, FFT load port and frame hand-off signals of the frame loader.
interface fft_frame_loader_if #(
  parameter int width = 16,
  parameter int M     = 5
);
  logic                    s_valid;
  logic                    s_ready;
  logic signed [width-M-1:0] s_data;
  logic                    fft_reset;
  logic                    fft_load;
  logic [M-1:0]            fft_rd_adr;
  logic [2*width-1:0]      fft_rd;
  logic                    fft_start;
  logic                    fft_done;
  logic                    frame_ready;
  logic                    frame_ack;
  logic [7:0]              frame_count;

  modport master (
    input  s_valid, s_data, fft_done, frame_ack,
    output s_ready, fft_reset, fft_load, fft_rd_adr, fft_rd, fft_start,
           frame_ready, frame_count
  );

  modport slave (
    output s_valid, s_data, fft_done, frame_ack,
    input  s_ready, fft_reset, fft_load, fft_rd_adr, fft_rd, fft_start,
           frame_ready, frame_count
  );
endinterface

// File: rtl/fft_frame_loader_window_rom.sv
// Hann window coefficient ROM (Q0.16, 32 points); only built with FFT_FRAME_LOADER_WINDOW_EN.
`ifdef FFT_FRAME_LOADER_WINDOW_EN
module fft_window_rom #(
  parameter int M  = 5,
  parameter int CW = 16
) (
  input  logic [M-1:0]  i_adr,
  output logic [CW-1:0] o_coef
);
  logic [M-1:0] w_fold;

  // The window is symmetric about N/2, so only the first half is tabulated.
  always_comb begin
    w_fold = i_adr;
    if (i_adr[M-1] && (i_adr[M-2:0] != {(M-1){1'b0}})) begin
      w_fold = {M{1'b0}} - i_adr;
    end else begin
      w_fold = i_adr;
    end
    case (w_fold)
      5'd0:    o_coef = 16'h0000;
      5'd1:    o_coef = 16'h0276;
      5'd2:    o_coef = 16'h09BE;
      5'd3:    o_coef = 16'h1592;
      5'd4:    o_coef = 16'h257D;
      5'd5:    o_coef = 16'h38E3;
      5'd6:    o_coef = 16'h4F04;
      5'd7:    o_coef = 16'h6707;
      5'd8:    o_coef = 16'h8000;
      5'd9:    o_coef = 16'h98F8;
      5'd10:   o_coef = 16'hB0FB;
      5'd11:   o_coef = 16'hC71C;
      5'd12:   o_coef = 16'hDA82;
      5'd13:   o_coef = 16'hEA6D;
      5'd14:   o_coef = 16'hF641;
      5'd15:   o_coef = 16'hFD89;
      default: o_coef = 16'hFFFF;
    endcase
  end
endmodule
`endif

// File: rtl/fft_frame_loader.sv
// Loads one N-point frame of packed complex samples into the FFT, runs it and hands it downstream.
// Optional Hann windowing of each sample is enabled by FFT_FRAME_LOADER_WINDOW_EN.
module fft_frame_loader
  import fft_frame_pkg::*;
#(
  parameter int width = 16,
  parameter int M     = 5,
  parameter int CW    = 16
) (
  input logic               clk,
  input logic               reset,
  fft_frame_loader_if.master bus
);
  state_t             r_state;
  logic [M-1:0]       r_index;
  logic               r_s_ready;
  logic               r_fft_reset;
  logic               r_fft_load;
  logic [M-1:0]       r_fft_rd_adr;
  logic [2*width-1:0] r_fft_rd;
  logic               r_fft_start;
  logic               r_frame_ready;
  logic [7:0]         r_frame_count;

  logic signed [width-M-1:0] w_sample;
  logic [31:0]               w_ext;
  logic [width-1:0]          w_real;
  logic                      w_unused_ext;

`ifdef FFT_FRAME_LOADER_WINDOW_EN
  logic [CW-1:0]               w_coef;
  logic signed [width-M+CW:0]  w_prod;
  logic                        w_unused_prod;

  fft_window_rom #(.M(M), .CW(CW)) u_window_rom (
    .i_adr  (r_index),
    .o_coef (w_coef)
  );

  // Coefficient is unsigned, so it gets a zero sign bit before the signed multiply.
  assign w_prod        = bus.s_data * $signed({1'b0, w_coef});
  assign w_sample      = w_prod[CW +: (width-M)];
  assign w_unused_prod = ^{w_prod[CW-1:0], w_prod[width-M+CW]};
`else
  assign w_sample = bus.s_data;
`endif

  assign w_ext        = sext({{(32-(width-M)){1'b0}}, w_sample}, width-M);
  assign w_real       = w_ext[width-1:0];
  assign w_unused_ext = ^w_ext[31:width];

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= CLEAR;
      r_index       <= {M{1'b0}};
      r_s_ready     <= 1'b0;
      r_fft_reset   <= 1'b0;
      r_fft_load    <= 1'b0;
      r_fft_rd_adr  <= {M{1'b0}};
      r_fft_rd      <= {(2*width){1'b0}};
      r_fft_start   <= 1'b0;
      r_frame_ready <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_fft_reset   <= 1'b1;
          r_s_ready     <= 1'b0;
          r_fft_load    <= 1'b0;
          r_fft_start   <= 1'b0;
          r_frame_ready <= 1'b0;
          r_index       <= {M{1'b0}};
          r_state       <= LOAD;
        end
        LOAD: begin
          r_fft_reset <= 1'b0;
          r_fft_start <= 1'b0;
          if (bus.s_valid && r_s_ready) begin
            r_fft_load   <= 1'b1;
            r_fft_rd_adr <= r_index;
            r_fft_rd     <= {w_real, {width{1'b0}}};
            r_index      <= r_index + {{(M-1){1'b0}}, 1'b1};
            if (r_index == {M{1'b1}}) begin
              r_s_ready <= 1'b0;
              r_state   <= FLUSH;
            end else begin
              r_s_ready <= 1'b1;
            end
          end else begin
            r_fft_load <= 1'b0;
            r_s_ready  <= 1'b1;
          end
        end
        FLUSH: begin
          r_s_ready   <= 1'b0;
          r_fft_load  <= 1'b0;
          r_fft_start <= 1'b1;
          r_state     <= START;
        end
        START: begin
          r_fft_start <= 1'b0;
          r_state     <= RUN;
        end
        RUN: begin
          if (bus.fft_done) begin
            r_frame_ready <= 1'b1;
            r_state       <= HOLD;
          end else begin
            r_state <= RUN;
          end
        end
        HOLD: begin
          if (bus.frame_ack) begin
            r_frame_ready <= 1'b0;
            r_frame_count <= r_frame_count + 8'd1;
            r_state       <= CLEAR;
          end else begin
            r_frame_ready <= 1'b1;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign bus.s_ready     = r_s_ready;
  assign bus.fft_reset   = r_fft_reset;
  assign bus.fft_load    = r_fft_load;
  assign bus.fft_rd_adr  = r_fft_rd_adr;
  assign bus.fft_rd      = r_fft_rd;
  assign bus.fft_start   = r_fft_start;
  assign bus.frame_ready = r_frame_ready;
  assign bus.frame_count = r_frame_count;
endmodule
